// File: rtl/axi4_w_arb.sv
// axi4_w_arb: round-robin arbiter that funnels single-beat write requests
// from NREQ requesters onto one AXI4 write master port. Only one write is
// in flight at a time. AW and W complete independently. The owner receives
// a one-cycle o_done pulse together with the captured BRESP.
module axi4_w_arb #(
  parameter int NREQ = 2,
  parameter int TAGW = 3,
  parameter int ADRW = 32,
  parameter int DATW = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*ADRW-1:0]     i_req_addr,
  input  logic [NREQ*DATW-1:0]     i_req_data,
  input  logic [NREQ*(DATW/8)-1:0] i_req_strb,
  output logic [NREQ-1:0]          o_req_ready,
  output logic [NREQ-1:0]          o_done,
  output logic [1:0]               o_resp,
  output logic                     o_busy,
  output logic [TAGW-1:0]          o_m_awid,
  output logic [ADRW-1:0]          o_m_awaddr,
  output logic [7:0]               o_m_awlen,
  output logic [2:0]               o_m_awsize,
  output logic [1:0]               o_m_awburst,
  output logic                     o_m_awvalid,
  input  logic                     i_m_awready,
  output logic [DATW-1:0]          o_m_wdata,
  output logic [DATW/8-1:0]        o_m_wstrb,
  output logic                     o_m_wlast,
  output logic                     o_m_wvalid,
  input  logic                     i_m_wready,
  input  logic [TAGW-1:0]          i_m_bid,
  input  logic [1:0]               i_m_bresp,
  input  logic                     i_m_bvalid,
  output logic                     o_m_bready
);

  localparam int STBW = DATW / 8;
  localparam int IDXW = $clog2(NREQ);
  localparam logic [2:0] AWSIZE = 3'($clog2(STBW));
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   last_q;
  logic [IDXW-1:0]   owner_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic [NREQ-1:0]   done_q;
  logic [1:0]        resp_q;
  logic [ADRW-1:0]   awaddr_q;
  logic [DATW-1:0]   wdata_q;
  logic [STBW-1:0]   wstrb_q;

  logic [IDXW-1:0]   cand_d [NREQ];
  logic              grant_vld_d;
  logic [IDXW-1:0]   grant_idx_d;
  logic              aw_hs;
  logic              w_hs;

  // BID carries no information here because only one write is ever outstanding.
  logic unused_bid;
  assign unused_bid = ^i_m_bid;

  assign aw_hs = awvalid_q & i_m_awready;
  assign w_hs  = wvalid_q & i_m_wready;

  // Candidate order for round robin: last_grant+1, last_grant+2, ... modulo NREQ
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      cand_d[k] = IDXW'((int'(last_q) + k + 1) % NREQ);
    end
  end

  // Pick the first requesting candidate in round-robin order
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_vld_d && i_req_valid[cand_d[k]]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = cand_d[k];
      end
    end
  end

  // Accept pulse is combinational so the requester sees it in the grant cycle;
  // it is suppressed while reset is asserted so nothing is accepted and then lost.
  assign o_req_ready = (!i_rst && state_q == IDLE && grant_vld_d)
                       ? (ONE_HOT0 << grant_idx_d) : '0;

  // Transfer FSM: grant/latch in IDLE, independent AW/W in XFER, B in RESP
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      last_q    <= IDXW'(NREQ - 1);
      owner_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      done_q    <= '0;
      resp_q    <= 2'b00;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            owner_q   <= grant_idx_d;
            awaddr_q  <= i_req_addr[int'(grant_idx_d) * ADRW +: ADRW];
            wdata_q   <= i_req_data[int'(grant_idx_d) * DATW +: DATW];
            wstrb_q   <= i_req_strb[int'(grant_idx_d) * STBW +: STBW];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= XFER;
          end
        end
        XFER: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          // Simultaneous completion moves straight on; otherwise the move
          // happens once both valids have been observed low.
          if ((aw_hs && w_hs) || (!awvalid_q && !wvalid_q)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (i_m_bvalid) begin
            done_q  <= ONE_HOT0 << owner_q;
            resp_q  <= i_m_bresp;
            last_q  <= owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_done      = done_q;
  assign o_resp      = resp_q;
  assign o_busy      = (state_q != IDLE);
  assign o_m_bready  = (state_q == RESP);

  assign o_m_awid    = '0;
  assign o_m_awaddr  = awaddr_q;
  assign o_m_awlen   = 8'd0;
  assign o_m_awsize  = AWSIZE;
  assign o_m_awburst = 2'b01;
  assign o_m_awvalid = awvalid_q;

  assign o_m_wdata   = wdata_q;
  assign o_m_wstrb   = wstrb_q;
  assign o_m_wvalid  = wvalid_q;
  assign o_m_wlast   = wvalid_q;

endmodule

// File: tb/tb_axi4_w_arb.sv
// tb_axi4_w_arb: directed scenarios plus randomized traffic for axi4_w_arb.
// Outputs are compared with a transaction-level timing model every cycle.
module tb_axi4_w_arb;

  localparam int NREQ = 3;
  localparam int TAGW = 3;
  localparam int ADRW = 32;
  localparam int DATW = 256;
  localparam int STBW = DATW / 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ADRW-1:0]  req_addr;
  logic [NREQ*DATW-1:0]  req_data;
  logic [NREQ*STBW-1:0]  req_strb;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       done;
  logic [1:0]            resp;
  logic                  busy;
  logic [TAGW-1:0]       awid;
  logic [ADRW-1:0]       awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATW-1:0]       wdata;
  logic [STBW-1:0]       wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [TAGW-1:0]       bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  axi4_w_arb #(.NREQ(NREQ), .TAGW(TAGW), .ADRW(ADRW), .DATW(DATW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data), .i_req_strb(req_strb),
    .o_req_ready(req_ready), .o_done(done), .o_resp(resp), .o_busy(busy),
    .o_m_awid(awid), .o_m_awaddr(awaddr), .o_m_awlen(awlen), .o_m_awsize(awsize),
    .o_m_awburst(awburst), .o_m_awvalid(awvalid), .i_m_awready(awready),
    .o_m_wdata(wdata), .o_m_wstrb(wstrb), .o_m_wlast(wlast), .o_m_wvalid(wvalid),
    .i_m_wready(wready),
    .i_m_bid(bid), .i_m_bresp(bresp), .i_m_bvalid(bvalid), .o_m_bready(bready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [DATW-1:0] obs, input logic [DATW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Requester side
  bit              pend   [NREQ];
  logic [ADRW-1:0] p_addr [NREQ];
  logic [DATW-1:0] p_data [NREQ];
  logic [STBW-1:0] p_strb [NREQ];

  // Stimulus knobs
  int              new_pct  = 0;
  int              drop_pct = 0;
  logic [NREQ-1:0] req_mask = '1;
  int              rdy_mode = 1;   // 0 random, 1 immediate, 2 awready late, 3 stalled
  bit              use_force = 1'b0;
  logic [1:0]      force_resp = 2'b00;
  bit              rst_now = 1'b0;

  // Reference model: one outstanding transaction described by event cycles
  bit              m_out = 1'b0;
  int              m_own = 0;
  int              m_g = 0;
  int              m_awhs = -1;
  int              m_whs = -1;
  int              m_last = NREQ - 1;
  int              m_done_cyc = -1;
  int              m_done_own = 0;
  logic [1:0]      m_resp = 2'b00;
  bit              m_after_rst = 1'b0;
  logic [ADRW-1:0] m_addr;
  logic [DATW-1:0] m_data;
  logic [STBW-1:0] m_strb;

  // Observations of DUT output edges for the directed latency checks
  bit         prev_aw = 1'b0, prev_w = 1'b0, prev_b = 1'b0;
  int         aw_fall = -1, w_fall = -1, b_rise = -1;
  int         done_cnt = 0;
  int         last_done_cyc = -1;
  logic [1:0] last_done_resp = 2'b00;
  int         g_own[$];
  int         g_cyc[$];

  function automatic logic [DATW-1:0] rnd_data();
    logic [DATW-1:0] r;
    for (int i = 0; i < DATW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic new_req(input int n, input logic [ADRW-1:0] a);
    pend[n]   = 1'b1;
    p_addr[n] = a;
    p_data[n] = rnd_data();
    p_strb[n] = STBW'($urandom);
  endtask

  task automatic mark_phase();
    aw_fall = -1;
    w_fall  = -1;
    b_rise  = -1;
    g_own.delete();
    g_cyc.delete();
  endtask

  task automatic step();
    logic [NREQ-1:0] e_rdy, e_done;
    bit e_aw, e_w, e_b, e_busy;
    int rs, pick;
    @(negedge clk);
    cyc++;
    for (int n = 0; n < NREQ; n++) begin
      if (!pend[n] && req_mask[n] && int'($urandom_range(99)) < new_pct)
        new_req(n, $urandom);
      else if (pend[n] && int'($urandom_range(99)) < drop_pct)
        pend[n] = 1'b0;
      req_valid[n]               = pend[n];
      req_addr[n*ADRW +: ADRW]   = p_addr[n];
      req_data[n*DATW +: DATW]   = p_data[n];
      req_strb[n*STBW +: STBW]   = p_strb[n];
    end
    case (rdy_mode)
      0: begin
        awready = ($urandom_range(3) != 0);
        wready  = ($urandom_range(3) != 0);
        bvalid  = ($urandom_range(2) != 0);
      end
      1: begin awready = 1'b1; wready = 1'b1; bvalid = 1'b1; end
      2: begin awready = m_out && (cyc >= m_g + 5); wready = 1'b1; bvalid = 1'b1; end
      default: begin awready = 1'b0; wready = 1'b0; bvalid = 1'b1; end
    endcase
    bresp = use_force ? force_resp : ((rdy_mode == 0) ? 2'($urandom_range(3)) : 2'b00);
    bid   = TAGW'($urandom);
    rst   = rst_now;
    #1;
    // Expected outputs from the transaction's event cycles
    e_aw   = m_out && (cyc > m_g) && (m_awhs < 0);
    e_w    = m_out && (cyc > m_g) && (m_whs < 0);
    rs     = 1 << 30;
    if (m_awhs >= 0 && m_whs >= 0)
      rs = (m_awhs == m_whs) ? m_awhs + 1 : ((m_awhs > m_whs) ? m_awhs : m_whs) + 2;
    e_b    = m_out && (cyc >= rs);
    e_busy = m_out && (cyc > m_g);
    e_done = '0;
    if (cyc == m_done_cyc) e_done[m_done_own] = 1'b1;
    pick  = -1;
    e_rdy = '0;
    if (!rst_now && !m_out) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (pick < 0 && pend[idx]) pick = idx;
      end
      if (pick >= 0) e_rdy[pick] = 1'b1;
    end
    chk("req_ready", DATW'(req_ready), DATW'(e_rdy));
    chk("done",      DATW'(done),      DATW'(e_done));
    chk("awvalid",   DATW'(awvalid),   DATW'(e_aw));
    chk("wvalid",    DATW'(wvalid),    DATW'(e_w));
    chk("wlast",     DATW'(wlast),     DATW'(e_w));
    chk("bready",    DATW'(bready),    DATW'(e_b));
    chk("busy",      DATW'(busy),      DATW'(e_busy));
    if (e_done != '0) chk("resp", DATW'(resp), DATW'(m_resp));
    if (e_aw) chk("awaddr", DATW'(awaddr), DATW'(m_addr));
    if (e_w) begin
      chk("wdata", wdata, m_data);
      chk("wstrb", DATW'(wstrb), DATW'(m_strb));
    end
    if (m_after_rst) begin
      chk("rst_resp",   DATW'(resp),   '0);
      chk("rst_awaddr", DATW'(awaddr), '0);
      chk("rst_wdata",  wdata,         '0);
      chk("rst_wstrb",  DATW'(wstrb),  '0);
      m_after_rst = 1'b0;
    end
    // Observed edges
    if (aw_fall < 0 && prev_aw && !awvalid) aw_fall = cyc;
    if (w_fall < 0 && prev_w && !wvalid) w_fall = cyc;
    if (b_rise < 0 && !prev_b && bready) b_rise = cyc;
    prev_aw = awvalid;
    prev_w  = wvalid;
    prev_b  = bready;
    if (done != '0) begin
      done_cnt++;
      last_done_cyc  = cyc;
      last_done_resp = resp;
    end
    // Advance the model across the coming clock edge
    if (rst_now) begin
      m_out       = 1'b0;
      m_last      = NREQ - 1;
      m_done_cyc  = -1;
      m_after_rst = 1'b1;
    end else begin
      if (e_aw && awready) m_awhs = cyc;
      if (e_w && wready)   m_whs  = cyc;
      if (e_b && bvalid) begin
        m_done_cyc = cyc + 1;
        m_done_own = m_own;
        m_resp     = bresp;
        m_last     = m_own;
        m_out      = 1'b0;
      end
      if (pick >= 0) begin
        m_out  = 1'b1;
        m_own  = pick;
        m_g    = cyc;
        m_addr = p_addr[pick];
        m_data = p_data[pick];
        m_strb = p_strb[pick];
        m_awhs = -1;
        m_whs  = -1;
        pend[pick] = 1'b0;
        g_own.push_back(pick);
        g_cyc.push_back(cyc);
      end
    end
  endtask

  initial begin
    int g0, d0;
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0; req_strb = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    for (int n = 0; n < NREQ; n++) begin
      pend[n] = 1'b0; p_addr[n] = '0; p_data[n] = '0; p_strb[n] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", DATW'(req_ready), '0);
    chk("rst_done",      DATW'(done),      '0);
    chk("rst_busy",      DATW'(busy),      '0);
    chk("rst_awvalid",   DATW'(awvalid),   '0);
    chk("rst_wvalid",    DATW'(wvalid),    '0);
    chk("rst_bready",    DATW'(bready),    '0);
    chk("rst_resp0",     DATW'(resp),      '0);
    chk("rst_awaddr0",   DATW'(awaddr),    '0);
    chk("rst_wdata0",    wdata,            '0);
    chk("rst_wstrb0",    DATW'(wstrb),     '0);
    chk("awid",          DATW'(awid),      '0);
    chk("awlen",         DATW'(awlen),     '0);
    chk("awsize",        DATW'(awsize),    DATW'(5));
    chk("awburst",       DATW'(awburst),   DATW'(1));

    // Single write on requester 0 with everything ready
    mark_phase();
    pend[0] = 1'b1; p_addr[0] = 32'h0000_1000; p_data[0] = rnd_data(); p_strb[0] = '1;
    repeat (6) step();
    g0 = (g_cyc.size() > 0) ? g_cyc[0] : -100;
    chk("single_owner",  DATW'((g_own.size() > 0) ? g_own[0] : -1), DATW'(0));
    chk("single_bready", DATW'(b_rise - g0), DATW'(2));
    chk("single_done",   DATW'(last_done_cyc - g0), DATW'(3));
    chk("single_resp",   DATW'(last_done_resp), DATW'(0));

    // Contention: req0 and req1 held continuously from reset
    new_pct = 100; req_mask = 3'b011;
    rst_now = 1'b1; step(); rst_now = 1'b0;
    mark_phase();
    repeat (13) step();
    chk("rr_count", DATW'(g_own.size() >= 4), DATW'(1));
    for (int k = 0; k < 4 && k < g_own.size(); k++) begin
      chk("rr_owner", DATW'(g_own[k]), DATW'(k % 2));
      if (k > 0) chk("rr_gap", DATW'(g_cyc[k] - g_cyc[k-1]), DATW'(3));
    end
    new_pct = 0; req_mask = '1;
    repeat (4) step();
    for (int n = 0; n < NREQ; n++) pend[n] = 1'b0;
    repeat (4) step();

    // Skewed handshake: awready four cycles late, wready immediate
    mark_phase();
    rdy_mode = 2;
    new_req(0, 32'h0000_2040);
    repeat (10) step();
    g0 = (g_cyc.size() > 0) ? g_cyc[0] : -100;
    chk("skew_wfall",  DATW'(w_fall - g0),  DATW'(2));
    chk("skew_awfall", DATW'(aw_fall - g0), DATW'(6));
    chk("skew_resp",   DATW'(b_rise - g0),  DATW'(7));

    // Error response passes through, next request unaffected
    rdy_mode = 1; use_force = 1'b1; force_resp = 2'b10;
    d0 = done_cnt;
    new_req(1, 32'h0000_3000);
    repeat (5) step();
    chk("err_resp",  DATW'(last_done_resp), DATW'(2));
    chk("err_count", DATW'(done_cnt - d0),  DATW'(1));
    use_force = 1'b0;
    new_req(2, 32'h0000_4000);
    repeat (5) step();
    chk("post_err_resp",  DATW'(last_done_resp), DATW'(0));
    chk("post_err_count", DATW'(done_cnt - d0),  DATW'(2));

    // Reset while AW is pending, then stray B beats
    rdy_mode = 3;
    new_req(0, 32'h0000_5000);
    repeat (2) step();
    chk("xfer_awvalid", DATW'(awvalid), DATW'(1));
    d0 = done_cnt;
    rst_now = 1'b1; step(); rst_now = 1'b0;
    repeat (4) step();
    chk("xfer_no_done", DATW'(done_cnt - d0), DATW'(0));
    chk("xfer_idle",    DATW'(busy),          DATW'(0));

    // Randomized traffic with occasional resets
    rdy_mode = 0; new_pct = 30; drop_pct = 5;
    repeat (3000) begin
      rst_now = ($urandom_range(499) == 0);
      step();
    end
    rst_now = 1'b0; new_pct = 0; drop_pct = 0; rdy_mode = 1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_w_arb.md
AXI4_W_ARB -- requirements
Module: axi4_w_arb

Interface
REQ-001 NREQ, 2: number of write requesters; range 2..8.
REQ-002 TAGW, 3: AXI ID width.
REQ-003 ADRW, 32: address width.
REQ-004 DATW, 256: data width; STBW = DATW/8; o_m_awsize = log2(STBW).
REQ-005 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 i_rst  in  1  reset, synchronous and active-high.
REQ-007 i_req_valid  in  NREQ  per-requester write request.
REQ-008 i_req_addr  in  NREQ*ADRW  per-requester address; requester n occupies slice [n*ADRW +: ADRW].
REQ-009 i_req_data  in  NREQ*DATW  per-requester single-beat data; same slicing rule.
REQ-010 i_req_strb  in  NREQ*STBW  per-requester byte strobes; same slicing rule.
REQ-011 o_req_ready  out  NREQ  one-hot, one-cycle accept pulse.
REQ-012 o_done  out  NREQ  one-hot, one-cycle completion pulse to the owner.
REQ-013 o_resp  out  2  captured BRESP; valid only with o_done.
REQ-014 o_busy  out  1  high whenever the state is not IDLE.
REQ-015 o_m_awid  out  TAGW  constant 0.
REQ-016 o_m_awaddr  out  ADRW  registered address.
REQ-017 o_m_awlen  out  8  constant 0 (single beat).
REQ-018 o_m_awsize  out  3  constant per REQ-004.
REQ-019 o_m_awburst  out  2  constant 2'b01 (INCR).
REQ-020 o_m_awvalid  out  1 / i_m_awready  in  1  AW handshake.
REQ-021 o_m_wdata  out  DATW / o_m_wstrb  out  STBW  registered write data and strobes.
REQ-022 o_m_wlast  out  1  equal to o_m_wvalid.
REQ-023 o_m_wvalid  out  1 / i_m_wready  in  1  W handshake.
REQ-024 i_m_bid  in  TAGW (ignored) / i_m_bresp  in  2 / i_m_bvalid  in  1 / o_m_bready  out  1  B channel.

Function
REQ-025 The block SHALL have three states: IDLE, XFER, RESP; at most one write SHALL be outstanding.
REQ-026 IDLE: when any i_req_valid bit is set, the block SHALL grant round-robin, starting at requester (last_grant+1) mod NREQ.
- On grant: pulse o_req_ready[g]; latch the address, data and strobes of requester g.
- Assert o_m_awvalid and o_m_wvalid together on the next cycle; go to XFER.
REQ-027 XFER: AW and W SHALL complete independently.
- Each valid drops the cycle after its own valid&ready handshake.
- The state SHALL move to RESP only once both handshakes have completed; if both complete in the same cycle, RESP is entered on the next cycle.
REQ-028 The AW and W payload outputs SHALL hold stable while the corresponding valid is high.
REQ-029 o_m_bready SHALL be high only in RESP.
REQ-030 RESP: on i_m_bvalid, the block SHALL, in the same edge:
- pulse o_done[g];
- drive o_resp = i_m_bresp;
- update last_grant = g;
- return to IDLE.
REQ-031 A B handshake that occurs outside RESP SHALL be ignored and SHALL NOT produce o_done.
REQ-032 Back-to-back operation: a request pending in the cycle after o_done SHALL be granted in that cycle.
- Minimum spacing between grants: 3 cycles when awready, wready and bvalid are returned immediately.
REQ-033 A requester SHALL hold valid and payload until its o_req_ready.
- A valid withdrawn before grant SHALL be ignored without error.
REQ-034 o_req_ready and o_done SHALL each be zero or one-hot in every cycle.
REQ-035 Non-zero BRESP SHALL be passed through on o_resp without retry.

Reset
REQ-036 While i_rst is high, the block SHALL:
- enter IDLE and set last_grant = NREQ-1 (requester 0 has priority first);
- drive o_m_awvalid, o_m_wvalid, o_m_bready, o_req_ready, o_done, o_busy = 0;
- set o_resp, o_m_awaddr, o_m_wdata, o_m_wstrb = 0.
REQ-037 Reset asserted mid-transfer SHALL abort the transfer without generating o_done; any later B beat is handled per REQ-031.

Verification
REQ-038 Single write: req0 addr 0x1000, strb all-ones, ready signals tied high -> o_req_ready[0] at T, AW/W valid at T+1, bready at T+2, bvalid at T+2 -> o_done[0] with o_resp=0.
REQ-039 Contention: req0 and req1 held continuously from reset -> grant order 0,1,0,1, each grant 3 cycles apart.
REQ-040 Skewed handshake: awready delayed 4 cycles, wready immediate -> wvalid drops at T+2, awvalid drops at T+6, RESP entered at T+7, payload stable throughout.
REQ-041 Error response: bresp=2'b10 -> o_done pulses with o_resp=2'b10; the next request proceeds normally.
REQ-042 Reset in XFER: i_rst for 1 cycle while awvalid is high -> all outputs zero the next cycle; no o_done; stray bvalid ignored.
